// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// funct codes, the aluop field and the ALU operation codes.
package mc_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_RSVD  = 2'b11
   } aluop_t;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_alu_dec.sv
// Combinational ALU decoder: aluop plus funct field to a 3-bit ALU operation.
// Shared with the single-cycle core, so it carries no state.
module alu_dec
   import mc_controller_pkg::*;
(
   input  aluop_t      i_aluop,
   input  logic [5:0]  i_funct,
   output logic [2:0]  o_alucontrol
);

   always_comb begin
      o_alucontrol = ALU_ADD;
      case (i_aluop)
         ALUOP_ADD: o_alucontrol = ALU_ADD;
         ALUOP_SUB: o_alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_funct)
               FN_ADD:  o_alucontrol = ALU_ADD;
               FN_SUB:  o_alucontrol = ALU_SUB;
               FN_AND:  o_alucontrol = ALU_AND;
               FN_OR:   o_alucontrol = ALU_OR;
               FN_SLT:  o_alucontrol = ALU_SLT;
               default: o_alucontrol = ALU_ADD;
            endcase
         end
         default: o_alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: a Moore FSM whose state register is the only
// flop; pcen is the single output that also looks at the ALU zero flag.
module mc_controller
   import mc_controller_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic        zero,
   output logic        pcen,
   output logic        memwrite,
   output logic        irwrite,
   output logic        regwrite,
   output logic        alusrca,
   output logic        iord,
   output logic        memtoreg,
   output logic        regdst,
   output logic [1:0]  alusrcb,
   output logic [1:0]  pcsrc,
   output logic [2:0]  alucontrol
);

   state_t r_state;
   state_t w_state_next;
   aluop_t w_aluop;
   logic   w_pcwrite;
   logic   w_branch;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = S_FETCH;
      case (r_state)
         S_FETCH: w_state_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: w_state_next = S_MEMADR;
               OP_RTYPE:     w_state_next = S_EXEC;
               OP_BEQ:       w_state_next = S_BRANCH;
               OP_ADDI:      w_state_next = S_ADDIEX;
               OP_J:         w_state_next = S_JUMP;
               default:      w_state_next = S_FETCH;
            endcase
         end
         // Only lw and sw reach MEMADR; anything else there is treated as sw.
         S_MEMADR: w_state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_state_next = S_MEMWB;
         S_EXEC:   w_state_next = S_ALUWB;
         S_ADDIEX: w_state_next = S_ADDIWB;
         default:  w_state_next = S_FETCH;
      endcase
   end

   always_comb begin
      w_pcwrite = 1'b0;
      w_branch  = 1'b0;
      w_aluop   = ALUOP_ADD;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      regwrite  = 1'b0;
      alusrca   = 1'b0;
      iord      = 1'b0;
      memtoreg  = 1'b0;
      regdst    = 1'b0;
      alusrcb   = 2'b00;
      pcsrc     = 2'b00;
      case (r_state)
         S_FETCH: begin
            irwrite   = 1'b1;
            w_pcwrite = 1'b1;
            alusrcb   = 2'b01;
         end
         S_DECODE: alusrcb = 2'b11;
         S_MEMADR, S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            w_aluop = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         S_BRANCH: begin
            alusrca  = 1'b1;
            w_aluop  = ALUOP_SUB;
            pcsrc    = 2'b01;
            w_branch = 1'b1;
         end
         S_ADDIWB: regwrite = 1'b1;
         S_JUMP: begin
            pcsrc     = 2'b10;
            w_pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   assign pcen = w_pcwrite | (w_branch & zero);

   alu_dec u_alu_dec (
      .i_aluop      (w_aluop),
      .i_funct      (funct),
      .o_alucontrol (alucontrol)
   );

endmodule

// File: tb/tb_mc_controller.sv
// Directed table-driven bench for mc_controller, plus hand sequences for the
// combinational branch enable and reset in the middle of a load.
module tb_mc_controller;

   logic        clk;
   logic        reset;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic        zero;
   logic        pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
   logic [1:0]  alusrcb, pcsrc;
   logic [2:0]  alucontrol;

   mc_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .pcen       (pcen),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .iord       (iord),
      .memtoreg   (memtoreg),
      .regdst     (regdst),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pcen,memwrite,irwrite,regwrite,alusrca,iord,memtoreg,regdst,alusrcb,pcsrc,alucontrol}
   localparam logic [14:0] E_FETCH  = 15'b1_0_1_0_0_0_0_0_01_00_010;
   localparam logic [14:0] E_DECODE = 15'b0_0_0_0_0_0_0_0_11_00_010;
   localparam logic [14:0] E_MEMADR = 15'b0_0_0_0_1_0_0_0_10_00_010;
   localparam logic [14:0] E_MEMRD  = 15'b0_0_0_0_0_1_0_0_00_00_010;
   localparam logic [14:0] E_MEMWB  = 15'b0_0_0_1_0_0_1_0_00_00_010;
   localparam logic [14:0] E_MEMWR  = 15'b0_1_0_0_0_1_0_0_00_00_010;
   localparam logic [14:0] E_ALUWB  = 15'b0_0_0_1_0_0_0_1_00_00_010;
   localparam logic [14:0] E_ADDIWB = 15'b0_0_0_1_0_0_0_0_00_00_010;
   localparam logic [14:0] E_JUMP   = 15'b1_0_0_0_0_0_0_0_00_10_010;

   function automatic logic [14:0] e_exec(input logic [2:0] alu);
      return {8'b0000_1000, 2'b00, 2'b00, alu};
   endfunction

   function automatic logic [14:0] e_branch(input logic z);
      return {z, 7'b000_1000, 2'b00, 2'b01, 3'b110};
   endfunction

   typedef struct {
      logic [95:0] name;
      logic        rst;
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      logic [14:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_vec;
   int   n_err;

   task automatic add(input logic [95:0] nm, input logic r, input logic [5:0] o,
                      input logic [5:0] f, input logic z, input logic [14:0] e);
      vec_t v;
      v.name = nm; v.rst = r; v.op = o; v.funct = f; v.zero = z; v.exp = e;
      vecs.push_back(v);
   endtask

   function automatic logic [14:0] actual();
      return {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
              alusrcb, pcsrc, alucontrol};
   endfunction

   task automatic check15(input logic [95:0] nm, input logic [14:0] exp);
      logic [14:0] act;
      act = actual();
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %0s: got %b expected %b", nm, act, exp);
      end else begin
         $display("ok   %0s: %b", nm, act);
      end
   endtask

   task automatic check1(input logic [95:0] nm, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %0s: got %b expected %b", nm, act, exp);
      end else begin
         $display("ok   %0s: %b", nm, act);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;

      add("reset",      1, 6'b100011, 6'd0, 0, E_FETCH);
      // lw: 5 cycles
      add("lw_decode",  0, 6'b100011, 6'd0, 0, E_DECODE);
      add("lw_memadr",  0, 6'b100011, 6'd0, 0, E_MEMADR);
      add("lw_memrd",   0, 6'b100011, 6'd0, 0, E_MEMRD);
      add("lw_memwb",   0, 6'b100011, 6'd0, 0, E_MEMWB);
      add("lw_fetch",   0, 6'b100011, 6'd0, 0, E_FETCH);
      // R-type sub
      add("sub_decode", 0, 6'b000000, 6'b100010, 0, E_DECODE);
      add("sub_exec",   0, 6'b000000, 6'b100010, 0, e_exec(3'b110));
      add("sub_aluwb",  0, 6'b000000, 6'b100010, 0, E_ALUWB);
      add("sub_fetch",  0, 6'b000000, 6'b100010, 0, E_FETCH);
      // beq taken / not taken
      add("beq1_dec",   0, 6'b000100, 6'd0, 1, E_DECODE);
      add("beq1_br",    0, 6'b000100, 6'd0, 1, e_branch(1'b1));
      add("beq1_fetch", 0, 6'b000100, 6'd0, 1, E_FETCH);
      add("beq0_dec",   0, 6'b000100, 6'd0, 0, E_DECODE);
      add("beq0_br",    0, 6'b000100, 6'd0, 0, e_branch(1'b0));
      add("beq0_fetch", 0, 6'b000100, 6'd0, 0, E_FETCH);
      // sw: 4 cycles, no regwrite anywhere
      add("sw_decode",  0, 6'b101011, 6'd0, 0, E_DECODE);
      add("sw_memadr",  0, 6'b101011, 6'd0, 0, E_MEMADR);
      add("sw_memwr",   0, 6'b101011, 6'd0, 0, E_MEMWR);
      add("sw_fetch",   0, 6'b101011, 6'd0, 0, E_FETCH);
      // unsupported opcode then jump
      add("nop_decode", 0, 6'b111111, 6'd0, 0, E_DECODE);
      add("nop_fetch",  0, 6'b111111, 6'd0, 0, E_FETCH);
      add("j_decode",   0, 6'b000010, 6'd0, 0, E_DECODE);
      add("j_jump",     0, 6'b000010, 6'd0, 0, E_JUMP);
      add("j_fetch",    0, 6'b000010, 6'd0, 0, E_FETCH);
      // addi
      add("addi_dec",   0, 6'b001000, 6'd0, 0, E_DECODE);
      add("addi_ex",    0, 6'b001000, 6'd0, 0, E_MEMADR);
      add("addi_wb",    0, 6'b001000, 6'd0, 0, E_ADDIWB);
      add("addi_fetch", 0, 6'b001000, 6'd0, 0, E_FETCH);
      // remaining funct decodes in EXEC
      add("and_dec",    0, 6'b000000, 6'b100100, 0, E_DECODE);
      add("and_exec",   0, 6'b000000, 6'b100100, 0, e_exec(3'b000));
      add("and_aluwb",  0, 6'b000000, 6'b100100, 0, E_ALUWB);
      add("and_fetch",  0, 6'b000000, 6'b100100, 0, E_FETCH);
      add("or_dec",     0, 6'b000000, 6'b100101, 0, E_DECODE);
      add("or_exec",    0, 6'b000000, 6'b100101, 0, e_exec(3'b001));
      add("or_aluwb",   0, 6'b000000, 6'b100101, 0, E_ALUWB);
      add("or_fetch",   0, 6'b000000, 6'b100101, 0, E_FETCH);
      add("slt_dec",    0, 6'b000000, 6'b101010, 0, E_DECODE);
      add("slt_exec",   0, 6'b000000, 6'b101010, 0, e_exec(3'b111));
      add("slt_aluwb",  0, 6'b000000, 6'b101010, 0, E_ALUWB);
      add("slt_fetch",  0, 6'b000000, 6'b101010, 0, E_FETCH);
      add("add_dec",    0, 6'b000000, 6'b100000, 0, E_DECODE);
      add("add_exec",   0, 6'b000000, 6'b100000, 0, e_exec(3'b010));
      add("add_aluwb",  0, 6'b000000, 6'b100000, 0, E_ALUWB);
      add("add_fetch",  0, 6'b000000, 6'b100000, 0, E_FETCH);
      add("bad_f_dec",  0, 6'b000000, 6'b111000, 0, E_DECODE);
      add("bad_f_exec", 0, 6'b000000, 6'b111000, 0, e_exec(3'b010));
      add("bad_f_wb",   0, 6'b000000, 6'b111000, 0, E_ALUWB);
      add("bad_f_fet",  0, 6'b000000, 6'b111000, 0, E_FETCH);

      foreach (vecs[i]) begin
         reset = vecs[i].rst;
         op    = vecs[i].op;
         funct = vecs[i].funct;
         zero  = vecs[i].zero;
         @(posedge clk);
         #1;
         check15(vecs[i].name, vecs[i].exp);
      end

      // pcen must follow zero combinationally while in BRANCH
      reset = 1'b0; op = 6'b000100; funct = 6'd0; zero = 1'b0;
      @(posedge clk); #1;
      check15("hb_decode", E_DECODE);
      @(posedge clk); #1;
      check15("hb_br_z0", e_branch(1'b0));
      zero = 1'b1; #1;
      check1("hb_pcen_z1", pcen, 1'b1);
      zero = 1'b0; #1;
      check1("hb_pcen_z0", pcen, 1'b0);
      @(posedge clk); #1;
      check15("hb_fetch", E_FETCH);

      // reset in MEMRD of a lw abandons the pending register write
      op = 6'b100011;
      @(posedge clk); #1;
      check15("hr_decode", E_DECODE);
      @(posedge clk); #1;
      check15("hr_memadr", E_MEMADR);
      @(posedge clk); #1;
      check15("hr_memrd", E_MEMRD);
      reset = 1'b1;
      @(posedge clk); #1;
      check15("hr_reset", E_FETCH);
      reset = 1'b0; op = 6'b111111;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check1("hr_no_rw", regwrite, 1'b0);
         check1("hr_no_mw", memwrite, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
